rvfpm_result_fifo: RTL

//  Result buffer placed directly downstream of the FPU result interface. It sits between the FPU and the core's XIF result port.

---
 rtl/rvfpm_result_fifo.sv | 85 ++++++++
 1 files changed

// File: rtl/rvfpm_result_fifo.sv
// In-order result buffer between the FPU result interface and the core's XIF result port.
// It decouples FPU writeback from core stalls. When full, it backpressures the FPU through in_ready.
module rvfpm_result_fifo #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int FLEN       = 32,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [X_ID_WIDTH-1:0] in_id,
  input  logic [FLEN-1:0]       in_data,
  input  logic [4:0]            in_rd,
  input  logic                  in_we,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [X_ID_WIDTH-1:0] result_id,
  output logic [FLEN-1:0]       result_data,
  output logic [4:0]            result_rd,
  output logic                  result_we,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int EW    = X_ID_WIDTH + FLEN + 6;

  logic [EW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [EW-1:0]    in_entry;
  logic [EW-1:0]    head;
  logic [EW-1:0]    held_q;
  logic             stall_q;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_entry     = {in_id, in_data, in_rd, in_we};
  assign in_ready     = count < CNT_W'(DEPTH);
  assign result_valid = count != '0;
  // flush overrides both handshakes, so a same-cycle push is dropped on purpose
  assign push         = in_valid && in_ready && !flush;
  assign pop          = result_valid && result_ready && !flush;

  // Stale slot contents never leak out while the FIFO is empty
  assign head = result_valid ? mem[rd_ptr] : '0;
  assign {result_id, result_data, result_rd, result_we} = head;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      stall_q      <= 1'b0;
      held_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_entry;
          wr_ptr      <= wrap_inc(wr_ptr);
        end
        if (pop) rd_ptr <= wrap_inc(rd_ptr);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
      // A refused offer must be held unchanged until it is taken
      stall_q <= in_valid && !in_ready;
      held_q  <= in_entry;
      if (stall_q && (!in_valid || in_entry != held_q)) overflow_err <= 1'b1;
    end
  end

endmodule
